register_rename_unit: RTL and testbench

- Parametrised register-renaming register file for the out-of-order MIPS core.
- Maps architectural registers to a physical register pool at decode and tracks in-flight allocations in a circular active list.
- Frees old mappings on in-order commit.
- Adds per-register ready bits and a multi-cycle flush/rollback state machine that walks the active list backwards to restore the map table.
- Sits between decode (rename/read) and writeback/commit.

---
 rtl/register_rename_unit.sv | 211 +++++++++++++++++++++
 tb/tb_register_rename_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_rename_unit.sv
// register_rename_unit: rename stage register file for the out-of-order MIPS core.
// Holds the arch->phys map table, a circular free list of physical registers,
// a circular active list of in-flight allocations, the physical register file
// with ready bits, and a rollback FSM that walks the active list backwards.
// Optional feature macro: WB_BYPASS_EN forwards same-cycle writeback data to reads.
module register_rename_unit #(
    parameter int DATA_WIDTH      = 32,
    parameter int ARCH_ADDR_WIDTH = 5,
    parameter int FREE_WIDTH      = 4,
    parameter int PREG_ADDR_WIDTH = 6,
    parameter int AL_WIDTH        = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall_in,
    input  logic [ARCH_ADDR_WIDTH-1:0] dec_rs_addr,
    input  logic [ARCH_ADDR_WIDTH-1:0] dec_rt_addr,
    input  logic [ARCH_ADDR_WIDTH-1:0] dec_rd_addr,
    input  logic                       dec_rd_write,
    output logic [DATA_WIDTH-1:0]      rs_data,
    output logic [DATA_WIDTH-1:0]      rt_data,
    output logic [PREG_ADDR_WIDTH-1:0] physical_rs_addr,
    output logic [PREG_ADDR_WIDTH-1:0] physical_rt_addr,
    output logic                       rs_ready,
    output logic                       rt_ready,
    output logic [PREG_ADDR_WIDTH-1:0] physical_rd_addr,
    output logic [AL_WIDTH-1:0]        al_index,
    input  logic                       wb_write_enable,
    input  logic [PREG_ADDR_WIDTH-1:0] wb_physical_addr,
    input  logic [DATA_WIDTH-1:0]      wb_data,
    input  logic [AL_WIDTH-1:0]        wb_al_index,
    input  logic                       flush,
    output logic                       commit_valid,
    output logic [ARCH_ADDR_WIDTH-1:0] commit_arch_addr,
    output logic                       stall_out,
    output logic                       busy
);
    localparam int ARCH_REGS  = 1 << ARCH_ADDR_WIDTH;
    localparam int FREE_DEPTH = 1 << FREE_WIDTH;
    localparam int PREG_COUNT = ARCH_REGS + FREE_DEPTH;
    localparam int AL_DEPTH   = 1 << AL_WIDTH;
    localparam logic [FREE_WIDTH-1:0] FL_ONE    = FREE_WIDTH'(1);
    localparam logic [AL_WIDTH-1:0]   AL_ONE    = AL_WIDTH'(1);
    localparam logic [FREE_WIDTH:0]   FREE_FULL = (FREE_WIDTH+1)'(FREE_DEPTH);
    localparam logic [AL_WIDTH:0]     AL_FULL   = (AL_WIDTH+1)'(AL_DEPTH);

    typedef struct packed {
        logic [ARCH_ADDR_WIDTH-1:0] rd;
        logic [PREG_ADDR_WIDTH-1:0] old_preg;
        logic [PREG_ADDR_WIDTH-1:0] new_preg;
        logic                       done;
    } al_entry_t;

    typedef enum logic {IDLE, ROLLBACK} state_t;

    state_t state_q, state_d;
    logic [ARCH_REGS-1:0][PREG_ADDR_WIDTH-1:0]  map_q, map_d;
    logic [FREE_DEPTH-1:0][PREG_ADDR_WIDTH-1:0] fl_q, fl_d;
    logic [FREE_WIDTH-1:0] fl_head_q, fl_head_d, fl_tail_q, fl_tail_d;
    logic [FREE_WIDTH:0]   free_count_q, free_count_d;
    al_entry_t [AL_DEPTH-1:0] al_q, al_d;
    logic [AL_WIDTH-1:0]   al_head_q, al_head_d, al_tail_q, al_tail_d;
    logic [AL_WIDTH:0]     al_count_q, al_count_d;
    logic [PREG_COUNT-1:0][DATA_WIDTH-1:0] rf_q, rf_d;
    logic [PREG_COUNT-1:0] rdy_q, rdy_d;
    logic                  commit_valid_q, commit_valid_d;
    logic [ARCH_ADDR_WIDTH-1:0] commit_arch_addr_q, commit_arch_addr_d;

    logic                rd_req, alloc, do_commit, rb_step;
    logic [AL_WIDTH-1:0] rb_idx;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: flush starts the walk, leave once the last entry is undone
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (flush) state_d = ROLLBACK;
            ROLLBACK: if (al_count_q <= (AL_WIDTH+1)'(1)) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == ROLLBACK);
    end

    // Stall, allocate/commit/rollback decisions and rename outputs
    always_comb begin
        rd_req    = dec_rd_write && (dec_rd_addr != '0);
        stall_out = busy || (rd_req && (free_count_q == '0 || al_count_q == AL_FULL));
        alloc     = rd_req && !stall_in && !stall_out && !flush;
        do_commit = (state_q == IDLE) && !flush && (al_count_q != '0) && al_q[al_head_q].done;
        rb_step   = (state_q == ROLLBACK) && (al_count_q != '0);
        rb_idx    = al_tail_q - AL_ONE;
        physical_rd_addr = alloc ? fl_q[fl_head_q] : '0;
        al_index         = al_tail_q;
        commit_valid     = commit_valid_q;
        commit_arch_addr = commit_arch_addr_q;
    end

    // Source reads; arch 0 always reads as zero and ready
    always_comb begin
        physical_rs_addr = map_q[dec_rs_addr];
        physical_rt_addr = map_q[dec_rt_addr];
        rs_data  = (dec_rs_addr == '0) ? '0 : rf_q[physical_rs_addr];
        rt_data  = (dec_rt_addr == '0) ? '0 : rf_q[physical_rt_addr];
        rs_ready = (dec_rs_addr == '0) ? 1'b1 : rdy_q[physical_rs_addr];
        rt_ready = (dec_rt_addr == '0) ? 1'b1 : rdy_q[physical_rt_addr];
`ifdef WB_BYPASS_EN
        if (wb_write_enable && wb_physical_addr != '0 && wb_physical_addr == physical_rs_addr) begin
            rs_data  = wb_data;
            rs_ready = 1'b1;
        end
        if (wb_write_enable && wb_physical_addr != '0 && wb_physical_addr == physical_rt_addr) begin
            rt_data  = wb_data;
            rt_ready = 1'b1;
        end
`endif
    end

    // Next-state datapath: writeback, commit, allocate, rollback step
    always_comb begin
        map_d              = map_q;
        fl_d               = fl_q;
        fl_head_d          = fl_head_q;
        fl_tail_d          = fl_tail_q;
        al_d               = al_q;
        al_head_d          = al_head_q;
        al_tail_d          = al_tail_q;
        rf_d               = rf_q;
        rdy_d              = rdy_q;
        commit_valid_d     = do_commit;
        commit_arch_addr_d = commit_arch_addr_q;
        free_count_d = free_count_q + (FREE_WIDTH+1)'(do_commit) + (FREE_WIDTH+1)'(rb_step)
                     - (FREE_WIDTH+1)'(alloc);
        al_count_d   = al_count_q + (AL_WIDTH+1)'(alloc) - (AL_WIDTH+1)'(do_commit)
                     - (AL_WIDTH+1)'(rb_step);

        // physical 0 is hard-wired to arch 0 and never written
        if (wb_write_enable && wb_physical_addr != '0 && int'(wb_physical_addr) < PREG_COUNT) begin
            rf_d[wb_physical_addr]  = wb_data;
            rdy_d[wb_physical_addr] = 1'b1;
            if (state_q == IDLE) al_d[wb_al_index].done = 1'b1;
        end

        // retire head: the superseded mapping becomes free
        if (do_commit) begin
            fl_d[fl_tail_q]    = al_q[al_head_q].old_preg;
            fl_tail_d          = fl_tail_q + FL_ONE;
            al_head_d          = al_head_q + AL_ONE;
            commit_arch_addr_d = al_q[al_head_q].rd;
        end

        if (alloc) begin
            map_d[dec_rd_addr]      = fl_q[fl_head_q];
            rdy_d[fl_q[fl_head_q]]  = 1'b0;
            fl_head_d               = fl_head_q + FL_ONE;
            al_d[al_tail_q]         = '{rd: dec_rd_addr, old_preg: map_q[dec_rd_addr],
                                        new_preg: fl_q[fl_head_q], done: 1'b0};
            al_tail_d               = al_tail_q + AL_ONE;
        end

        // undo youngest entry: restore old mapping, recycle the new register
        if (rb_step) begin
            map_d[al_q[rb_idx].rd]      = al_q[rb_idx].old_preg;
            fl_d[fl_tail_q]             = al_q[rb_idx].new_preg;
            rdy_d[al_q[rb_idx].new_preg] = 1'b1;
            fl_tail_d                   = fl_tail_q + FL_ONE;
            al_tail_d                   = rb_idx;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++)  map_q[i] <= PREG_ADDR_WIDTH'(i);
            for (int i = 0; i < FREE_DEPTH; i++) fl_q[i]  <= PREG_ADDR_WIDTH'(ARCH_REGS + i);
            fl_head_q          <= '0;
            fl_tail_q          <= '0;
            free_count_q       <= FREE_FULL;
            al_q               <= '0;
            al_head_q          <= '0;
            al_tail_q          <= '0;
            al_count_q         <= '0;
            rf_q               <= '0;
            rdy_q              <= '1;
            commit_valid_q     <= 1'b0;
            commit_arch_addr_q <= '0;
        end else begin
            map_q              <= map_d;
            fl_q               <= fl_d;
            fl_head_q          <= fl_head_d;
            fl_tail_q          <= fl_tail_d;
            free_count_q       <= free_count_d;
            al_q               <= al_d;
            al_head_q          <= al_head_d;
            al_tail_q          <= al_tail_d;
            al_count_q         <= al_count_d;
            rf_q               <= rf_d;
            rdy_q              <= rdy_d;
            commit_valid_q     <= commit_valid_d;
            commit_arch_addr_q <= commit_arch_addr_d;
        end
    end
endmodule

// File: tb/tb_register_rename_unit.sv
// tb_register_rename_unit: directed steps plus random traffic against a
// queue-based reference model of the rename unit.
module tb_register_rename_unit;
    localparam int AW = 5, PW = 6, LW = 4, DW = 32;
    localparam int ARCH = 32, FD = 16, PC = 48, AD = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic stall_in, dec_rd_write, wb_write_enable, flush;
    logic [AW-1:0] dec_rs_addr, dec_rt_addr, dec_rd_addr;
    logic [PW-1:0] wb_physical_addr;
    logic [DW-1:0] wb_data;
    logic [LW-1:0] wb_al_index;
    logic [DW-1:0] rs_data, rt_data;
    logic [PW-1:0] physical_rs_addr, physical_rt_addr, physical_rd_addr;
    logic rs_ready, rt_ready, commit_valid, stall_out, busy;
    logic [LW-1:0] al_index;
    logic [AW-1:0] commit_arch_addr;

    always #5 clk = ~clk;

    register_rename_unit dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
        .dec_rs_addr(dec_rs_addr), .dec_rt_addr(dec_rt_addr), .dec_rd_addr(dec_rd_addr),
        .dec_rd_write(dec_rd_write), .rs_data(rs_data), .rt_data(rt_data),
        .physical_rs_addr(physical_rs_addr), .physical_rt_addr(physical_rt_addr),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .physical_rd_addr(physical_rd_addr),
        .al_index(al_index), .wb_write_enable(wb_write_enable),
        .wb_physical_addr(wb_physical_addr), .wb_data(wb_data), .wb_al_index(wb_al_index),
        .flush(flush), .commit_valid(commit_valid), .commit_arch_addr(commit_arch_addr),
        .stall_out(stall_out), .busy(busy)
    );

    typedef struct { int rd; int oldp; int newp; bit done; } ent_t;
    int          m_map[ARCH];
    int          m_fl[$];
    ent_t        m_al[$];
    int          m_tail;
    logic [31:0] m_rf[PC];
    bit          m_rdy[PC];
    bit          m_busy, m_cv;
    int          m_ca;
    int          n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ARCH; i++) m_map[i] = i;
        m_fl.delete();
        for (int i = 0; i < FD; i++) m_fl.push_back(ARCH + i);
        m_al.delete();
        m_tail = 0;
        for (int i = 0; i < PC; i++) begin m_rf[i] = '0; m_rdy[i] = 1'b1; end
        m_busy = 0; m_cv = 0; m_ca = 0;
    endtask

    task automatic idle_in();
        stall_in = 0; dec_rd_write = 0; dec_rd_addr = '0; dec_rs_addr = '0; dec_rt_addr = '0;
        wb_write_enable = 0; wb_physical_addr = '0; wb_data = '0; wb_al_index = '0; flush = 0;
    endtask

    function automatic int m_head();
        return (m_tail - m_al.size() + AD) % AD;
    endfunction

    function automatic bit m_stall();
        return m_busy || (dec_rd_write && dec_rd_addr != 0 && (m_fl.size() == 0 || m_al.size() == AD));
    endfunction

    function automatic bit m_alloc();
        return dec_rd_write && dec_rd_addr != 0 && !stall_in && !m_stall() && !flush;
    endfunction

    task automatic chk_read(input string tag, input int a, input logic [PW-1:0] pa,
                            input logic [31:0] d, input logic r);
        int p;
        logic [31:0] ed;
        logic er;
        p  = m_map[a];
        ed = (a == 0) ? 32'd0 : m_rf[p];
        er = (a == 0) ? 1'b1 : m_rdy[p];
`ifdef WB_BYPASS_EN
        if (wb_write_enable && wb_physical_addr != 0 && int'(wb_physical_addr) == p) begin
            ed = wb_data; er = 1'b1;
        end
`endif
        chk({tag, "_paddr"}, pa, p);
        chk({tag, "_data"}, d, ed);
        chk({tag, "_ready"}, r, er);
    endtask

    // compare every combinational output against the model for current inputs
    task automatic check_now();
        #1;
        chk("stall_out", stall_out, m_stall());
        chk("busy", busy, m_busy);
        chk("commit_valid", commit_valid, m_cv);
        if (m_cv) chk("commit_arch", commit_arch_addr, m_ca);
        chk("phys_rd", physical_rd_addr, m_alloc() ? m_fl[0] : 0);
        chk("al_index", al_index, m_tail);
        chk_read("rs", dec_rs_addr, physical_rs_addr, rs_data, rs_ready);
        chk_read("rt", dec_rt_addr, physical_rt_addr, rt_data, rt_ready);
    endtask

    // advance the model by one clock using the current inputs, then clock the DUT
    task automatic tick();
        bit a, cm;
        int head, pos, p;
        ent_t e;
        a    = m_alloc();
        cm   = !m_busy && !flush && m_al.size() != 0 && m_al[0].done;
        head = m_head();
        if (wb_write_enable && wb_physical_addr != 0) begin
            m_rf[wb_physical_addr]  = wb_data;
            m_rdy[wb_physical_addr] = 1'b1;
            if (!m_busy) begin
                pos = (int'(wb_al_index) - head + AD) % AD;
                if (pos < m_al.size()) begin e = m_al[pos]; e.done = 1; m_al[pos] = e; end
            end
        end
        if (m_busy) begin
            m_cv = 0;
            if (m_al.size() != 0) begin
                e = m_al.pop_back();
                m_map[e.rd] = e.oldp;
                m_fl.push_back(e.newp);
                m_rdy[e.newp] = 1'b1;
                m_tail = (m_tail + AD - 1) % AD;
            end
            m_busy = (m_al.size() != 0);
        end else begin
            m_cv = cm;
            if (cm) begin
                e = m_al.pop_front();
                m_fl.push_back(e.oldp);
                m_ca = e.rd;
            end
            if (a) begin
                p = m_fl.pop_front();
                m_al.push_back('{rd: int'(dec_rd_addr), oldp: m_map[dec_rd_addr], newp: p, done: 0});
                m_map[dec_rd_addr] = p;
                m_rdy[p] = 1'b0;
                m_tail = (m_tail + 1) % AD;
            end
            if (flush) m_busy = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    // flush and wait (bounded) for the DUT rollback to finish
    task automatic drain();
        int n;
        n = 0;
        idle_in(); flush = 1; check_now(); tick();
        flush = 0;
        while (busy && n < 40) begin check_now(); tick(); n++; end
        chk("drain_done", busy, 1'b0);
    endtask

    initial begin
        int p, pos;
        int sched[3];
        int got[$];
        sched = '{2, 0, 1};
        idle_in();
        do_reset();

        // reset state and first rename
        dec_rs_addr = 7; check_now();
        chk("rst_rs_map", physical_rs_addr, 7);
        idle_in(); dec_rd_write = 1; dec_rd_addr = 3; check_now();
        chk("t1_prd", physical_rd_addr, 32);
        chk("t1_al_index", al_index, 0);
        tick();
        idle_in(); dec_rs_addr = 3; check_now();
        chk("t1_rs_map", physical_rs_addr, 32);
        chk("t1_rs_notready", rs_ready, 1'b0);
        tick();
        idle_in(); dec_rs_addr = 3; wb_write_enable = 1; wb_physical_addr = 32;
        wb_data = 32'hDEADBEEF; wb_al_index = 0; check_now(); tick();
        idle_in(); dec_rs_addr = 3; check_now();
        chk("t1_rs_data", rs_data, 32'hDEADBEEF);
        chk("t1_rs_ready", rs_ready, 1'b1);
        tick();
        idle_in(); check_now();
        chk("t1_commit_valid", commit_valid, 1'b1);
        chk("t1_commit_arch", commit_arch_addr, 3);
        tick();

        // fill the active list, then free one slot by committing
        for (int i = 0; i < 16; i++) begin
            idle_in(); dec_rd_write = 1; dec_rd_addr = AW'(i + 1); dec_rs_addr = AW'($urandom_range(0, 31));
            check_now(); chk("t2_nostall", stall_out, 1'b0); tick();
        end
        idle_in(); dec_rd_write = 1; dec_rd_addr = 20; check_now();
        chk("t2_full_stall", stall_out, 1'b1);
        chk("t2_full_prd", physical_rd_addr, 0);
        tick();
        idle_in(); wb_write_enable = 1; wb_physical_addr = PW'(m_al[0].newp);
        wb_al_index = LW'(m_head()); wb_data = 32'h1111; check_now(); tick();
        idle_in(); check_now(); tick();
        idle_in(); dec_rd_write = 1; dec_rd_addr = 20; check_now();
        chk("t2_commit_pulse", commit_valid, 1'b1);
        chk("t2_stall_drop", stall_out, 1'b0);
        tick();
        drain();

        // out-of-order writebacks retire in order
        for (int i = 0; i < 3; i++) begin
            idle_in(); dec_rd_write = 1; dec_rd_addr = AW'(i == 2 ? 4 : i + 1); check_now(); tick();
        end
        for (int c = 0; c < 7; c++) begin
            idle_in();
            if (c < 3) begin
                pos = sched[c] - (3 - m_al.size());
                wb_write_enable = 1; wb_physical_addr = PW'(m_al[pos].newp);
                wb_al_index = LW'((m_head() + pos) % AD); wb_data = $urandom;
            end
            check_now();
            if (commit_valid) got.push_back(int'(commit_arch_addr));
            tick();
        end
        chk("t3_ncommits", got.size(), 3);
        if (got.size() == 3) begin
            chk("t3_c0", got[0], 1); chk("t3_c1", got[1], 2); chk("t3_c2", got[2], 4);
        end

        // rollback of two renames of the same register
        do_reset();
        idle_in(); dec_rd_write = 1; dec_rd_addr = 5; check_now(); chk("t4_prd0", physical_rd_addr, 32); tick();
        idle_in(); dec_rd_write = 1; dec_rd_addr = 5; check_now(); chk("t4_prd1", physical_rd_addr, 33); tick();
        idle_in(); flush = 1; dec_rd_write = 1; dec_rd_addr = 9; check_now();
        chk("t4_flush_drop", physical_rd_addr, 0); tick();
        idle_in(); check_now(); chk("t4_busy1", busy, 1'b1); tick();
        idle_in(); check_now(); chk("t4_busy2", busy, 1'b1); tick();
        idle_in(); dec_rs_addr = 5; check_now();
        chk("t4_idle", busy, 1'b0);
        chk("t4_map5", physical_rs_addr, 5);
        chk("t4_al_index", al_index, 0);

        // non-allocating requests and writeback to physical 0
        idle_in(); dec_rd_write = 1; dec_rd_addr = 0; check_now(); chk("t5_rd0", physical_rd_addr, 0); tick();
        idle_in(); dec_rd_write = 1; dec_rd_addr = 7; stall_in = 1; check_now();
        chk("t5_stall_in", physical_rd_addr, 0); tick();
        idle_in(); wb_write_enable = 1; wb_physical_addr = 0; wb_data = 32'hFFFFFFFF; check_now(); tick();
        idle_in(); check_now();
        chk("t5_al_same", al_index, 0);
        chk("t5_rs0_data", rs_data, 0);
        chk("t5_rs0_ready", rs_ready, 1'b1);

        // same-cycle writeback against a read
        idle_in(); dec_rd_write = 1; dec_rd_addr = 3; check_now(); p = int'(physical_rd_addr); tick();
        idle_in(); dec_rs_addr = 3; wb_write_enable = 1; wb_physical_addr = PW'(p);
        wb_data = 32'h12345678; wb_al_index = LW'(m_head()); check_now();
`ifdef WB_BYPASS_EN
        chk("t6_bypass", rs_data, 32'h12345678);
`else
        chk("t6_nobypass", rs_data, 32'h0);
`endif
        tick();
        idle_in(); dec_rs_addr = 3; check_now(); chk("t6_after", rs_data, 32'h12345678); tick();

        // random traffic
        do_reset();
        for (int c = 0; c < 800; c++) begin
            idle_in();
            dec_rs_addr  = AW'($urandom_range(0, 31));
            dec_rt_addr  = AW'($urandom_range(0, 31));
            dec_rd_write = ($urandom_range(0, 3) != 0);
            dec_rd_addr  = AW'($urandom_range(0, 31));
            stall_in     = ($urandom_range(0, 9) == 0);
            if (!m_busy && m_al.size() != 0 && $urandom_range(0, 1) == 1) begin
                pos = $urandom_range(0, m_al.size() - 1);
                wb_write_enable = 1; wb_physical_addr = PW'(m_al[pos].newp);
                wb_al_index = LW'((m_head() + pos) % AD); wb_data = $urandom;
            end
            flush = ($urandom_range(0, 39) == 0);
            check_now();
            tick();
        end

        // reset in the middle of a rollback
        drain();
        for (int i = 0; i < 4; i++) begin
            idle_in(); dec_rd_write = 1; dec_rd_addr = AW'(i + 10); check_now(); tick();
        end
        idle_in(); flush = 1; check_now(); tick();
        idle_in(); check_now(); chk("rb_busy", busy, 1'b1); tick();
        do_reset();
        idle_in(); dec_rs_addr = 10; check_now();
        chk("rb_reset_busy", busy, 1'b0);
        chk("rb_reset_map", physical_rs_addr, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
